// File: rtl/max1270_ch_avg_if.sv
// Averaged-sample output stream of the MAX1270 channel averager.
// The master side produces channel-tagged averages, and the slave side
// applies back-pressure through m_axis_tready.
interface max1270_ch_avg_if;
  logic [11:0] m_axis_tdata;
  logic [2:0]  m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  modport master (
    output m_axis_tdata,
    output m_axis_tuser,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tdata,
    input  m_axis_tuser,
    input  m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/max1270_ch_avg.sv
// MAX1270 eight-channel window averager.
// The block snapshots the PHY channel registers on a programmable tick.
// It folds each snapshot into per-channel accumulators through one shared
// adder, one channel per cycle. After 2^LOG2_AVG snapshots it streams the
// eight truncated averages out with a channel tag. Averages above thr_hi
// raise sticky per-channel alarm bits.
module max1270_ch_avg #(
  parameter int SAMPLE_DIV = 2000,
  parameter int LOG2_AVG   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [11:0]           iADCh0Data,
  input  logic [11:0]           iADCh1Data,
  input  logic [11:0]           iADCh2Data,
  input  logic [11:0]           iADCh3Data,
  input  logic [11:0]           iADCh4Data,
  input  logic [11:0]           iADCh5Data,
  input  logic [11:0]           iADCh6Data,
  input  logic [11:0]           iADCh7Data,
  input  logic [11:0]           thr_hi,
  input  logic                  alarm_clr,
  max1270_ch_avg_if.master      axis,
  output logic [7:0]            alarm,
  output logic                  overrun
);

  localparam int DATA_W = 12;
  localparam int ACC_W  = DATA_W + LOG2_AVG;
  localparam int CNT_W  = $clog2(SAMPLE_DIV);
  localparam int WIN_W  = (LOG2_AVG > 0) ? LOG2_AVG : 1;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'((1 << LOG2_AVG) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         divCnt;
  logic                     tick;
  logic                     pending;
  logic [2:0]               ch;
  logic [2:0]               chNext;
  logic [WIN_W-1:0]         winCnt;
  logic [DATA_W-1:0]        chIn [8];
  logic [DATA_W-1:0]        snap [8];
  logic [ACC_W-1:0]         acc  [8];
  logic [DATA_W-1:0]        outData;
  logic [2:0]               outUser;
  logic                     outValid;

  // Window sum to average: plain right shift, the fraction is dropped.
  function automatic logic [DATA_W-1:0] avgOf(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0] shifted;
    shifted = sum >> LOG2_AVG;
    return shifted[DATA_W-1:0];
  endfunction

  // Unsigned strict over-threshold test. Equality does not alarm.
  function automatic logic overThr(input logic [DATA_W-1:0] value,
                                   input logic [DATA_W-1:0] limit);
    return value > limit;
  endfunction

  assign chNext = ch + 3'd1;

  // Gather the eight PHY ports into one indexable bundle.
  always_comb begin
    chIn[0] = iADCh0Data;
    chIn[1] = iADCh1Data;
    chIn[2] = iADCh2Data;
    chIn[3] = iADCh3Data;
    chIn[4] = iADCh4Data;
    chIn[5] = iADCh5Data;
    chIn[6] = iADCh6Data;
    chIn[7] = iADCh7Data;
  end

  // Sample-rate divider. It produces a one-cycle registered tick after the
  // terminal count. Disabling it rewinds the count, so re-enabling always
  // gives a full period before the first tick.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      divCnt <= '0;
      tick   <= 1'b0;
    end else begin
      tick   <= (divCnt == DIV_LAST);
      divCnt <= (divCnt == DIV_LAST) ? '0 : divCnt + 1'b1;
    end
  end

  // Snapshot capture. All eight channels are frozen on the same edge in
  // which IDLE accepts a tick, so SCAN/EMIT never see later input changes.
  always_ff @(posedge clk) begin
    if (state == IDLE && (tick || pending)) begin
      snap <= chIn;
    end
  end

  // Control FSM: tick bookkeeping, shared-adder scan, output stream, alarms.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      ch       <= '0;
      winCnt   <= '0;
      outValid <= 1'b0;
      outData  <= '0;
      outUser  <= '0;
      alarm    <= '0;
      overrun  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        acc[i] <= '0;
      end
    end else begin
      // The clear is applied first, so a set later in this cycle overrides it.
      if (alarm_clr) begin
        alarm   <= '0;
        overrun <= 1'b0;
      end

      // A busy engine can hold one tick in reserve. Any further tick is lost.
      if (state != IDLE && tick) begin
        if (pending) begin
          overrun <= 1'b1;
        end else begin
          pending <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (tick || pending) begin
            // Consuming a held tick while a fresh one arrives keeps the
            // fresh one in reserve.
            pending <= tick && pending;
            ch      <= '0;
            state   <= SCAN;
          end
        end

        SCAN: begin
          acc[ch] <= acc[ch] + ACC_W'(snap[ch]);
          ch      <= chNext;
          if (ch == 3'd7) begin
            if (winCnt == WIN_LAST) begin
              // acc[0] is already final here. Only acc[7] updates this edge.
              winCnt   <= '0;
              state    <= EMIT;
              outValid <= 1'b1;
              outData  <= avgOf(acc[0]);
              outUser  <= 3'd0;
            end else begin
              winCnt <= winCnt + 1'b1;
              state  <= IDLE;
            end
          end
        end

        EMIT: begin
          if (outValid && axis.m_axis_tready) begin
            acc[ch] <= '0;
            if (overThr(outData, thr_hi)) begin
              alarm[outUser] <= 1'b1;
            end
            ch <= chNext;
            if (ch == 3'd7) begin
              outValid <= 1'b0;
              state    <= IDLE;
            end else begin
              outUser <= chNext;
              outData <= avgOf(acc[chNext]);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign axis.m_axis_tdata  = outData;
  assign axis.m_axis_tuser  = outUser;
  assign axis.m_axis_tvalid = outValid;

endmodule

// File: tb/tb_max1270_ch_avg.sv
// Directed bench for the MAX1270 channel averager (LOG2_AVG=2, SAMPLE_DIV=16).
module tb_max1270_ch_avg;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [11:0] chVal [8];
  logic [11:0] thr_hi;
  logic        alarm_clr;
  logic [7:0]  alarm;
  logic        overrun;

  max1270_ch_avg_if axis ();

  max1270_ch_avg #(
    .SAMPLE_DIV (16),
    .LOG2_AVG   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .iADCh0Data (chVal[0]),
    .iADCh1Data (chVal[1]),
    .iADCh2Data (chVal[2]),
    .iADCh3Data (chVal[3]),
    .iADCh4Data (chVal[4]),
    .iADCh5Data (chVal[5]),
    .iADCh6Data (chVal[6]),
    .iADCh7Data (chVal[7]),
    .thr_hi     (thr_hi),
    .alarm_clr  (alarm_clr),
    .axis       (axis.master),
    .alarm      (alarm),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          nTests = 0;
  int          nFail  = 0;
  int          edgeN  = 0;
  int          base   = 0;
  logic [11:0] expD [8];
  logic        sawValid;

  task automatic step();
    @(posedge clk);
    #1;
    edgeN++;
  endtask

  task automatic gotoEdge(input int n);
    while (edgeN < n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Fresh start: reset with the divider stopped, then enable. Tick k then
  // follows edge base+16k, and the snapshot is taken on edge base+16k+1.
  task automatic restart();
    rst       = 1'b1;
    enable    = 1'b0;
    alarm_clr = 1'b0;
    axis.m_axis_tready = 1'b1;
    step();
    step();
    rst    = 1'b0;
    enable = 1'b1;
    base   = edgeN;
  endtask

  // Wait (bounded) for a window, then consume 8 beats with tready=1.
  task automatic expectWindow(input string tag);
    int n;
    n = 0;
    while (axis.m_axis_tvalid !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(axis.m_axis_tvalid), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_tuser"}, 32'(axis.m_axis_tuser), 32'(i));
      chk({tag, "_tdata"}, 32'(axis.m_axis_tdata), 32'(expD[i]));
      step();
    end
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    alarm_clr = 1'b0;
    thr_hi    = 12'd4095;
    axis.m_axis_tready = 1'b1;
    for (int k = 0; k < 8; k++) chVal[k] = 12'(100 * k + 5);

    // Reset state
    step(); step(); step();
    chk("rst_tvalid", 32'(axis.m_axis_tvalid), 32'd0);
    chk("rst_tdata",  32'(axis.m_axis_tdata),  32'd0);
    chk("rst_tuser",  32'(axis.m_axis_tuser),  32'd0);
    chk("rst_alarm",  32'(alarm),              32'd0);
    chk("rst_overrun", 32'(overrun),           32'd0);

    // 1: constant channels, latency 9 cycles after the 4th tick (edge base+64)
    restart();
    gotoEdge(base + 72);
    chk("t1_lat_pre", 32'(axis.m_axis_tvalid), 32'd0);
    for (int k = 0; k < 8; k++) expD[k] = 12'(100 * k + 5);
    step();
    chk("t1_lat_hit", 32'(axis.m_axis_tvalid), 32'd1);
    expectWindow("t1");
    chk("t1_tvalid_drop", 32'(axis.m_axis_tvalid), 32'd0);
    chk("t1_alarm", 32'(alarm), 32'd0);

    // 2: ch0 snapshots 10,11,12,14 -> 47/4 = 11; then constant 20 -> 20
    restart();
    for (int k = 0; k < 8; k++) chVal[k] = 12'd0;
    chVal[0] = 12'd10;
    gotoEdge(base + 17); chVal[0] = 12'd11;
    gotoEdge(base + 33); chVal[0] = 12'd12;
    gotoEdge(base + 49); chVal[0] = 12'd14;
    gotoEdge(base + 65); chVal[0] = 12'd20;
    for (int k = 0; k < 8; k++) expD[k] = 12'd0;
    expD[0] = 12'd11;
    expectWindow("t2_w1");
    expD[0] = 12'd20;
    expectWindow("t2_w2");

    // 3: full scale, alarms, clear, strict compare
    restart();
    for (int k = 0; k < 8; k++) chVal[k] = 12'd4095;
    for (int k = 0; k < 8; k++) expD[k] = 12'd4095;
    thr_hi = 12'd4000;
    expectWindow("t3_w1");
    chk("t3_alarm_set", 32'(alarm), 32'hFF);
    alarm_clr = 1'b1;
    step();
    alarm_clr = 1'b0;
    chk("t3_alarm_clr", 32'(alarm), 32'd0);
    thr_hi = 12'd4095;
    expectWindow("t3_w2");
    chk("t3_alarm_strict", 32'(alarm), 32'd0);
    chk("t3_overrun", 32'(overrun), 32'd0);

    // 4: back-pressure for 40 cycles, pending and overrun
    restart();
    thr_hi = 12'd4095;
    for (int k = 0; k < 8; k++) chVal[k] = 12'(100 * k + 5);
    axis.m_axis_tready = 1'b0;
    gotoEdge(base + 73);
    for (int i = 0; i < 40; i++) begin
      chk("t4_hold_valid", 32'(axis.m_axis_tvalid), 32'd1);
      chk("t4_hold_tdata", 32'(axis.m_axis_tdata),  32'd5);
      chk("t4_hold_tuser", 32'(axis.m_axis_tuser),  32'd0);
      if (i == 17) chk("t4_overrun_early", 32'(overrun), 32'd0);
      step();
    end
    chk("t4_overrun", 32'(overrun), 32'd1);
    // The held tick must snapshot this ch0 value right after the 8 beats.
    chVal[0] = 12'd40;
    axis.m_axis_tready = 1'b1;
    for (int k = 0; k < 8; k++) expD[k] = 12'(100 * k + 5);
    expectWindow("t4_w1");
    gotoEdge(base + 122);
    chVal[0] = 12'd0;
    expD[0] = 12'd10;
    expectWindow("t4_w2");

    // 5: reset during EMIT on beat 3
    restart();
    thr_hi = 12'd0;
    for (int k = 0; k < 8; k++) chVal[k] = 12'(100 * k + 5);
    gotoEdge(base + 76);
    chk("t5_beat3_tuser", 32'(axis.m_axis_tuser), 32'd3);
    chk("t5_beat3_alarm", 32'(alarm), 32'h07);
    rst = 1'b1;
    step();
    chk("t5_rst_tvalid", 32'(axis.m_axis_tvalid), 32'd0);
    chk("t5_rst_alarm",  32'(alarm), 32'd0);
    rst  = 1'b0;
    base = edgeN;
    sawValid = 1'b0;
    while (edgeN < base + 72) begin
      step();
      if (axis.m_axis_tvalid === 1'b1) sawValid = 1'b1;
    end
    chk("t5_no_early_beat", 32'(sawValid), 32'd0);
    step();
    chk("t5_first_valid", 32'(axis.m_axis_tvalid), 32'd1);
    chk("t5_first_tdata", 32'(axis.m_axis_tdata),  32'd5);

    // 6: enable low for 100 cycles, re-enable timing, clear vs set
    restart();
    thr_hi = 12'd4094;
    for (int k = 0; k < 8; k++) chVal[k] = 12'd0;
    chVal[0] = 12'd4095;
    gotoEdge(base + 40);
    enable = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (axis.m_axis_tvalid === 1'b1) sawValid = 1'b1;
    end
    chk("t6_disabled_quiet", 32'(sawValid), 32'd0);
    enable = 1'b1;
    base   = edgeN;
    gotoEdge(base + 40);
    chk("t6_reen_pre", 32'(axis.m_axis_tvalid), 32'd0);
    step();
    chk("t6_reen_valid", 32'(axis.m_axis_tvalid), 32'd1);
    chk("t6_reen_tdata", 32'(axis.m_axis_tdata),  32'd4095);
    alarm_clr = 1'b1;
    step();
    alarm_clr = 1'b0;
    chk("t6_set_wins", 32'(alarm), 32'h01);
    chk("t6_next_tuser", 32'(axis.m_axis_tuser), 32'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/max1270_ch_avg.md
Name: max1270_ch_avg

Overview:
Downstream consumer of the MAX1270 PHY's eight free-running 12-bit channel registers. It snapshots all eight channels on a programmable sample tick and accumulates 2^LOG2_AVG snapshots per channel through one time-multiplexed adder. It then emits the eight averages as a channel-tagged valid/ready stream and flags channels above a high threshold. It sits between the PHY and the AXI register/DMA layer.

Parameters:
SAMPLE_DIV, 2000, clk cycles between snapshot ticks (>= 16).
LOG2_AVG, 4, log2 of snapshots averaged per window (0..8).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  1 = tick counter runs
iADCh0Data..iADCh7Data  in  12 each  PHY channel values (8 ports)
thr_hi  in  12  alarm threshold, unsigned
alarm_clr  in  1  pulse, clears alarm and overrun
m_axis_tdata  out  12  averaged value
m_axis_tuser  out  3  channel index
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  downstream ready
alarm  out  8  sticky per-channel over-threshold flags
overrun  out  1  sticky: tick dropped

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Tick counter, channel index, window counter, accumulators, pending flag all 0.
- Tick generation:
  - While enable=1, the counter runs 0..SAMPLE_DIV-1 and wraps.
  - tick is a registered 1-cycle pulse in the cycle after the counter equals SAMPLE_DIV-1.
  - enable=0 clears the counter and generates no ticks. A scan or emit already in progress completes.
- Pending tick:
  - A tick seen while state != IDLE sets pending.
  - A tick while pending is already set is dropped and sets overrun.
  - In IDLE, tick or pending is consumed and pending clears. A new tick in that same cycle re-sets pending.
- Accumulators: 8 x (12+LOG2_AVG) bits, so there is no overflow at full scale.
- States:
  - IDLE: on tick or pending, copy all 8 inputs into snapshot registers in the same edge, set ch=0, go to SCAN.
  - SCAN: one channel per cycle, acc[ch] += snap[ch], ch++.
    - After ch=7: if window count = 2^LOG2_AVG-1, the count wraps to 0, ch=0, go to EMIT.
    - Otherwise the count increments and the block returns to IDLE.
  - EMIT:
    - tdata = acc[ch] >> LOG2_AVG (truncating), tuser = ch, tvalid = 1.
    - On handshake (tvalid & tready): clear acc[ch], evaluate the alarm, ch++.
    - After the beat for ch=7: tvalid drops the next cycle, go to IDLE.
- Latency: a tick in cycle T that closes a window gives tvalid=1 from cycle T+9 (1 snapshot + 8 scan cycles).
- Output stability: tdata and tuser stay stable while tvalid=1 and tready=0. tvalid never drops without a handshake, except on reset.
- Alarm:
  - On each handshake, if tdata > thr_hi (strictly greater), set alarm[tuser].
  - alarm_clr clears all alarm bits and overrun.
  - If a set and a clear land in the same cycle, the set wins for that bit and for overrun.
- Reset mid-operation: everything returns to reset values the next cycle. The first post-reset window always contains a full 2^LOG2_AVG snapshots.
- Inputs are sampled only at the snapshot edge. Changes during SCAN or EMIT do not affect the current snapshot.

Test Plan:
(Run with LOG2_AVG=2, SAMPLE_DIV=16.)
1. Constant channels: chk = 100k+5, tready=1, thr_hi=4095 -> after the 4th tick, 8 consecutive beats with tuser 0..7, tdata 5,105,...,705; alarm=0; tvalid first high 9 cycles after the 4th tick.
2. Ch0 snapshots 10,11,12,14 -> sum 47, tdata=11 (truncated); the next window with constant 20 -> tdata=20 (accumulator was cleared).
3. All channels 4095, thr_hi=4000 -> 8 beats of tdata 4095 and alarm=8'hFF. Pulse alarm_clr -> alarm=0. Then with thr_hi=4095 -> alarm stays 0 (strict compare).
4. tready=0 for 40 cycles at the start of EMIT:
   - tdata=5, tuser=0 held stable throughout.
   - First tick -> pending; second tick -> overrun=1.
   - After release, 8 beats complete, then the pending snapshot is taken immediately.
5. rst asserted during EMIT on beat 3 -> tvalid=0, alarm=0 the next cycle. After release, no beat appears until 4 new ticks have elapsed.
6. enable=0 for 100 cycles -> no tvalid. Re-enable -> first tick 16 cycles later. alarm_clr and a 4095 > thr_hi beat in the same cycle -> that alarm bit is set.
